event_rate_meter: RTL and testbench

//  Consumes single-cycle event pulses from the edge-filter stage and counts them over a

---
 rtl/event_rate_meter.sv | 145 ++++++++++++++
 tb/tb_event_rate_meter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/event_rate_meter.sv
// event_rate_meter
//   Counts single-cycle event pulses over a fixed window of WINDOW_CYCLES clocks
//   using a two-digit BCD accumulator that saturates at 99. At each window end the
//   count (and a saturation flag) is latched for display and the accumulator
//   restarts. The latched value drives a 2-digit multiplexed seven-segment output.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   event_pulse  in   event strobe; each high cycle counts as one event
//   enable       in   1 = measure; 0 = timer/accumulator held cleared
//   count_bcd    out  latched count of last completed window {tens,units}
//   overflow     out  latched: last completed window saw more than 99 events
//   window_done  out  one-cycle strobe in the cycle count_bcd/overflow update
//   digit_sel    out  0 = units digit on seg, 1 = tens digit on seg
//   seg          out  active-high segments {g,f,e,d,c,b,a}
module event_rate_meter #(
    parameter int unsigned WINDOW_CYCLES = 10_000_000,
    parameter int unsigned MUX_CYCLES    = 10_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       event_pulse,
    input  logic       enable,
    output logic [7:0] count_bcd,
    output logic       overflow,
    output logic       window_done,
    output logic       digit_sel,
    output logic [6:0] seg
);

    localparam int unsigned TW = $clog2(WINDOW_CYCLES);
    localparam int unsigned MW = (MUX_CYCLES > 1) ? $clog2(MUX_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(WINDOW_CYCLES - 1);
    localparam logic [MW-1:0] M_LAST = MW'(MUX_CYCLES - 1);

    logic [TW-1:0] timer;
    logic [3:0]    acc_tens;
    logic [3:0]    acc_units;
    logic          sat;

    logic [3:0]    nx_tens;
    logic [3:0]    nx_units;
    logic          nx_sat;
    logic          terminal;

    logic [MW-1:0] mux_cnt;
    logic [3:0]    digit;
    logic [6:0]    seg_next;

    assign terminal = enable && (timer == T_LAST);

    // Accumulator value including this cycle's event; used both for the running
    // count and for the latch on the terminal cycle.
    always_comb begin
        nx_tens  = acc_tens;
        nx_units = acc_units;
        nx_sat   = sat;
        if (event_pulse) begin
            if (acc_tens == 4'd9 && acc_units == 4'd9) begin
                nx_sat = 1'b1;
            end else if (acc_units == 4'd9) begin
                nx_units = 4'd0;
                nx_tens  = acc_tens + 4'd1;
            end else begin
                nx_units = acc_units + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer       <= '0;
            acc_tens    <= '0;
            acc_units   <= '0;
            sat         <= 1'b0;
            count_bcd   <= '0;
            overflow    <= 1'b0;
            window_done <= 1'b0;
        end else if (!enable) begin
            timer       <= '0;
            acc_tens    <= '0;
            acc_units   <= '0;
            sat         <= 1'b0;
            window_done <= 1'b0;
        end else if (terminal) begin
            timer       <= '0;
            acc_tens    <= '0;
            acc_units   <= '0;
            sat         <= 1'b0;
            count_bcd   <= {nx_tens, nx_units};
            overflow    <= nx_sat;
            window_done <= 1'b1;
        end else begin
            timer       <= timer + TW'(1);
            acc_tens    <= nx_tens;
            acc_units   <= nx_units;
            sat         <= nx_sat;
            window_done <= 1'b0;
        end
    end

    // Segment pattern for the digit currently selected; registered below so seg
    // trails digit_sel/count_bcd by one cycle.
    always_comb begin
        digit    = digit_sel ? count_bcd[7:4] : count_bcd[3:0];
        seg_next = 7'h00;
        if (overflow) begin
            seg_next = 7'h40;
        end else if (digit_sel && digit == 4'd0) begin
            seg_next = 7'h00;
        end else begin
            case (digit)
                4'd0:    seg_next = 7'h3F;
                4'd1:    seg_next = 7'h06;
                4'd2:    seg_next = 7'h5B;
                4'd3:    seg_next = 7'h4F;
                4'd4:    seg_next = 7'h66;
                4'd5:    seg_next = 7'h6D;
                4'd6:    seg_next = 7'h7D;
                4'd7:    seg_next = 7'h07;
                4'd8:    seg_next = 7'h7F;
                4'd9:    seg_next = 7'h6F;
                default: seg_next = 7'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mux_cnt   <= '0;
            digit_sel <= 1'b0;
            seg       <= 7'h3F;
        end else begin
            if (mux_cnt == M_LAST) begin
                mux_cnt   <= '0;
                digit_sel <= ~digit_sel;
            end else begin
                mux_cnt <= mux_cnt + MW'(1);
            end
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_event_rate_meter.sv
// tb_event_rate_meter
//   Bench for event_rate_meter: a short-window instance (16/4) driven from a
//   vector table with a window_done scoreboard, and a long-window instance
//   (200/4) for saturation and display-trailing sequences.
module tb_event_rate_meter;

    typedef struct {
        logic [15:0] mask;
        logic [7:0]  bcd;
        logic        ovf;
        logic [6:0]  units;
        logic [6:0]  tens;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       event_pulse;
    logic       enable;
    logic [7:0] count_bcd;
    logic       overflow;
    logic       window_done;
    logic       digit_sel;
    logic [6:0] seg;

    logic       ev_l;
    logic       en_l;
    logic [7:0] count_l;
    logic       ovf_l;
    logic       done_l;
    logic       sel_l;
    logic [6:0] seg_l;

    int checks   = 0;
    int failures = 0;

    vec_t q[$];
    vec_t vecs[10];

    always #5 clk = ~clk;

    event_rate_meter #(.WINDOW_CYCLES(16), .MUX_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .event_pulse(event_pulse), .enable(enable),
        .count_bcd(count_bcd), .overflow(overflow), .window_done(window_done),
        .digit_sel(digit_sel), .seg(seg)
    );

    event_rate_meter #(.WINDOW_CYCLES(200), .MUX_CYCLES(4)) dut_long (
        .clk(clk), .reset(reset), .event_pulse(ev_l), .enable(en_l),
        .count_bcd(count_l), .overflow(ovf_l), .window_done(done_l),
        .digit_sel(sel_l), .seg(seg_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor for the short instance: pops on window_done, then checks
    // the displayed segment pattern and the digit_sel period.
    int         settle = 0;
    int         run = 0;
    bit         run_valid = 0;
    logic       prev_sel = 1'b0;
    logic [6:0] disp_u = 7'h3F;
    logic [6:0] disp_t = 7'h00;

    always @(negedge clk) begin
        vec_t e;
        if (reset) begin
            settle    = 0;
            run       = 0;
            run_valid = 0;
            disp_u    = 7'h3F;
            disp_t    = 7'h00;
            prev_sel  = digit_sel;
        end else begin
            if (window_done) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_window_done actual=1 required=0 at %0t", $time);
                end else begin
                    e = q.pop_front();
                    check("win_count", 32'(count_bcd), 32'(e.bcd));
                    check("win_overflow", 32'(overflow), 32'(e.ovf));
                    disp_u = e.units;
                    disp_t = e.tens;
                end
                settle = 0;
            end else begin
                settle++;
            end
            if (settle >= 1 && digit_sel == prev_sel)
                check(digit_sel ? "seg_tens" : "seg_units", 32'(seg),
                      32'(digit_sel ? disp_t : disp_u));
            if (digit_sel != prev_sel) begin
                if (run_valid) check("sel_period", 32'(run), 32'd4);
                run_valid = 1;
                run = 1;
            end else begin
                run++;
            end
            prev_sel = digit_sel;
        end
    end

    task automatic drive_window(input vec_t v);
        q.push_back(v);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            enable      = 1'b1;
            event_pulse = v.mask[i];
        end
    endtask

    task automatic expect_done_next(input string name);
        check({name, "_early"}, 32'(window_done), 32'd0);
        @(negedge clk);
        enable      = 1'b0;
        event_pulse = 1'b0;
        check({name, "_latency"}, 32'(window_done), 32'd1);
    endtask

    task automatic long_window(input int n, input logic [7:0] bcd, input logic ovf,
                               input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            en_l = 1'b1;
            ev_l = (i < n);
        end
        @(negedge clk);
        en_l = 1'b0;
        ev_l = 1'b0;
        check({name, "_done"}, 32'(done_l), 32'd1);
        check({name, "_count"}, 32'(count_l), 32'(bcd));
        check({name, "_overflow"}, 32'(ovf_l), 32'(ovf));
    endtask

    initial begin
        vec_t v;
        logic prev;
        int   changes;

        vecs[0] = '{16'h001F, 8'h05, 1'b0, 7'h6D, 7'h00};
        vecs[1] = '{16'h0000, 8'h00, 1'b0, 7'h3F, 7'h00};
        vecs[2] = '{16'hFFFF, 8'h16, 1'b0, 7'h7D, 7'h06};
        vecs[3] = '{16'h8000, 8'h01, 1'b0, 7'h06, 7'h00};
        vecs[4] = '{16'h0001, 8'h01, 1'b0, 7'h06, 7'h00};
        vecs[5] = '{16'h5555, 8'h08, 1'b0, 7'h7F, 7'h00};
        vecs[6] = '{16'h03FF, 8'h10, 1'b0, 7'h3F, 7'h06};
        vecs[7] = '{16'h0FFF, 8'h12, 1'b0, 7'h5B, 7'h06};
        vecs[8] = '{16'h01FF, 8'h09, 1'b0, 7'h6F, 7'h00};
        vecs[9] = '{16'h7E00, 8'h06, 1'b0, 7'h7D, 7'h00};

        reset       = 1'b1;
        enable      = 1'b0;
        event_pulse = 1'b0;
        en_l        = 1'b0;
        ev_l        = 1'b0;
        #3;
        check("rst_count", 32'(count_bcd), 32'h00);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_done", 32'(window_done), 32'd0);
        check("rst_sel", 32'(digit_sel), 32'd0);
        check("rst_seg", 32'(seg), 32'h3F);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;

        // Back-to-back windows from the table, including terminal/first-cycle pulses.
        for (int k = 0; k < 10; k++) drive_window(vecs[k]);

        // Drop enable at timer=8 after 4 pulses; events while disabled are ignored.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            enable      = 1'b1;
            event_pulse = (i < 4);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            enable      = 1'b0;
            event_pulse = 1'b1;
        end
        check("hold_count", 32'(count_bcd), 32'h06);
        check("hold_overflow", 32'(overflow), 32'd0);
        v = '{16'h0003, 8'h02, 1'b0, 7'h5B, 7'h00};
        drive_window(v);
        expect_done_next("reenable");

        // Reset mid-window at timer=10 with 7 events accumulated.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            enable      = 1'b1;
            event_pulse = (i < 7);
        end
        @(negedge clk);
        enable      = 1'b0;
        event_pulse = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("midrst_count", 32'(count_bcd), 32'h00);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_done", 32'(window_done), 32'd0);
        check("midrst_sel", 32'(digit_sel), 32'd0);
        check("midrst_seg", 32'(seg), 32'h3F);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        v = '{16'h0111, 8'h03, 1'b0, 7'h4F, 7'h00};
        drive_window(v);
        expect_done_next("restart");

        // Long window: saturation, recovery, and display trailing digit_sel.
        long_window(120, 8'h99, 1'b1, "sat");
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("sat_seg_dash", 32'(seg_l), 32'h40);
        end
        long_window(3, 8'h03, 1'b0, "after_sat");
        long_window(27, 8'h27, 1'b0, "c27");
        repeat (2) @(negedge clk);
        prev    = sel_l;
        changes = 0;
        for (int i = 0; i < 20 && changes < 2; i++) begin
            @(negedge clk);
            if (sel_l != prev) begin
                check("trail_old_digit", 32'(seg_l), prev ? 32'h5B : 32'h07);
                @(negedge clk);
                check("trail_new_digit", 32'(seg_l), sel_l ? 32'h5B : 32'h07);
                prev = sel_l;
                changes++;
            end
        end
        if (changes < 2) begin
            checks++;
            failures++;
            $display("FAIL trail_sel_toggle actual=%0d required=2 toggles", changes);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
